// File: rtl/cacheline_pkg.sv
// cacheline_pkg: line/burst geometry and FSM state encoding shared by the cache-line adaptor.
package cacheline_pkg;
    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int BEATS   = LINE_W / BURST_W;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        RD_DONE,
        WR_BURST,
        WR_DONE
    } cla_state_t;
endpackage

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: 256-bit line <-> 4x64-bit memory burst bridge, one line transaction at a time.
// Define CACHELINE_ADAPTOR_PERF_EN to add rd_count_o/wr_count_o completion counters.
module cacheline_adaptor
    import cacheline_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
`ifdef CACHELINE_ADAPTOR_PERF_EN
    output logic [31:0]        rd_count_o,
    output logic [31:0]        wr_count_o,
`endif
    input  logic               resp_i
);
    cla_state_t        state_q, state_d;
    logic [1:0]        cnt_q;
    logic [LINE_W-1:0] wr_line_q;
    logic              accept;
    logic              beat;

    assign accept    = (state_q == IDLE) && (read_i || write_i);
    assign beat      = resp_i && (state_q == RD_BURST || state_q == WR_BURST);
    assign read_o    = (state_q == RD_BURST);
    assign write_o   = (state_q == WR_BURST);
    assign resp_o    = (state_q == RD_DONE) || (state_q == WR_DONE);
    assign burst_o   = write_o ? wr_line_q[BURST_W*cnt_q +: BURST_W] : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = write_i ? WR_BURST : read_i ? RD_BURST : IDLE;
            RD_BURST: state_d = (resp_i && cnt_q == LAST_BEAT) ? RD_DONE : RD_BURST;
            WR_BURST: state_d = (resp_i && cnt_q == LAST_BEAT) ? WR_DONE : WR_BURST;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_line_q <= '0;
            line_o    <= '0;
            address_o <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                address_o <= {address_i[31:5], 5'b0};
                cnt_q     <= '0;
                if (write_i)
                    wr_line_q <= line_i;
            end
            if (beat)
                cnt_q <= cnt_q + 2'd1;
            if (beat && read_o)
                line_o[BURST_W*cnt_q +: BURST_W] <= burst_i;
        end
    end

`ifdef CACHELINE_ADAPTOR_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count_o <= '0;
            wr_count_o <= '0;
        end else begin
            if (state_q == RD_DONE)
                rd_count_o <= rd_count_o + 32'd1;
            if (state_q == WR_DONE)
                wr_count_o <= wr_count_o + 32'd1;
        end
    end
`endif
endmodule
